// File: rtl/wb_queue.sv
// wb_queue: register-file write-back FIFO with a registered write port and
// newest-first forwarding lookup over pending entries and the output stage.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_f,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_reg,
    input  logic [31:0]             in_data,
    input  logic                    stall,
    output logic [3:0]              write_reg,
    output logic [31:0]             write_data,
    output logic                    rf_we,
    input  logic [3:0]              query_rega,
    input  logic [3:0]              query_regb,
    output logic                    fwd_hita,
    output logic                    fwd_hitb,
    output logic [31:0]             fwd_dataa,
    output logic [31:0]             fwd_datab,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    mem_reg_q  [DEPTH];
    logic [3:0]    mem_reg_d  [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [31:0]   mem_data_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [3:0]    write_reg_q, write_reg_d;
    logic [31:0]   write_data_q, write_data_d;

    logic          push;
    logic          pop;
    logic [32:0]   fwd_a;
    logic [32:0]   fwd_b;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready   = !full;
    assign count      = count_q;
    assign rf_we      = rf_we_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

    // Register 0 is never stored; an accepted R0 write is simply swallowed.
    assign push = in_valid && in_ready && (in_reg != 4'd0);
    assign pop  = !stall && !empty;

    // Scan oldest to newest so the last match (nearest tail) wins; the output
    // stage is older than every stored entry.
    function automatic logic [32:0] fwd_lookup(input logic [3:0] q);
        logic [32:0]   r;
        logic [AW-1:0] idx;
        r = '0;
        if (q != 4'd0) begin
            if (rf_we_q && (write_reg_q == q)) begin
                r = {1'b1, write_data_q};
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = head_q + AW'(i);
                if ((CW'(i) < count_q) && (mem_reg_q[idx] == q)) begin
                    r = {1'b1, mem_data_q[idx]};
                end
            end
        end
        return r;
    endfunction

    // Forwarding lookup for both decode read ports.
    always_comb begin
        fwd_a     = fwd_lookup(query_rega);
        fwd_b     = fwd_lookup(query_regb);
        fwd_hita  = fwd_a[32];
        fwd_dataa = fwd_a[31:0];
        fwd_hitb  = fwd_b[32];
        fwd_datab = fwd_b[31:0];
    end

    // Next-state: enqueue at tail, drain head into the registered write port.
    always_comb begin
        mem_reg_d    = mem_reg_q;
        mem_data_d   = mem_data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        rf_we_d      = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;

        if (pop) begin
            rf_we_d      = 1'b1;
            write_reg_d  = mem_reg_q[head_q];
            write_data_d = mem_data_q[head_q];
            head_d       = head_q + AW'(1);
        end

        if (push) begin
            mem_reg_d[tail_q]  = in_reg;
            mem_data_d[tail_q] = in_data;
            tail_d             = tail_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset clears pointers, storage and the write port.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            mem_reg_q    <= '{default: '0};
            mem_data_q   <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rf_we_q      <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            mem_reg_q    <= mem_reg_d;
            mem_data_q   <= mem_data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rf_we_q      <= rf_we_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed and randomized checks of wb_queue against a
// queue-based reference model of the write-back FIFO.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_f;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_reg;
    logic [31:0]   in_data;
    logic          stall;
    logic [3:0]    write_reg;
    logic [31:0]   write_data;
    logic          rf_we;
    logic [3:0]    query_rega;
    logic [3:0]    query_regb;
    logic          fwd_hita;
    logic          fwd_hitb;
    logic [31:0]   fwd_dataa;
    logic [31:0]   fwd_datab;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending entries plus the registered write port.
    logic [35:0] mq[$];
    logic        m_we;
    logic [3:0]  m_reg;
    logic [31:0] m_data;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .stall      (stall),
        .write_reg  (write_reg),
        .write_data (write_data),
        .rf_we      (rf_we),
        .query_rega (query_rega),
        .query_regb (query_regb),
        .fwd_hita   (fwd_hita),
        .fwd_hitb   (fwd_hitb),
        .fwd_dataa  (fwd_dataa),
        .fwd_datab  (fwd_datab),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    // Newest pending value for a register, searching from the tail backwards.
    task automatic model_fwd(input logic [3:0] q, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (q != 4'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i][35:32] == q) begin
                    hit  = 1'b1;
                    data = mq[i][31:0];
                    return;
                end
            end
            if (m_we && (m_reg == q)) begin
                hit  = 1'b1;
                data = m_data;
            end
        end
    endtask

    task automatic model_step(input logic v, input logic [3:0] r, input logic [31:0] d, input logic s);
        logic        acc;
        logic        pop;
        logic [35:0] e;
        acc = v && (mq.size() < DEPTH);
        pop = !s && (mq.size() > 0);
        if (pop) begin
            e      = mq.pop_front();
            m_we   = 1'b1;
            m_reg  = e[35:32];
            m_data = e[31:0];
        end else begin
            m_we = 1'b0;
        end
        if (acc && (r != 4'd0)) mq.push_back({r, d});
    endtask

    task automatic check_all();
        logic        ha, hb;
        logic [31:0] da, db;
        model_fwd(query_rega, ha, da);
        model_fwd(query_regb, hb, db);
        check("in_ready",   32'(in_ready),   32'(mq.size() < DEPTH));
        check("full",       32'(full),       32'(mq.size() == DEPTH));
        check("empty",      32'(empty),      32'(mq.size() == 0));
        check("count",      32'(count),      32'(mq.size()));
        check("rf_we",      32'(rf_we),      32'(m_we));
        check("write_reg",  32'(write_reg),  32'(m_reg));
        check("write_data", write_data,      m_data);
        check("fwd_hita",   32'(fwd_hita),   32'(ha));
        check("fwd_dataa",  fwd_dataa,       da);
        check("fwd_hitb",   32'(fwd_hitb),   32'(hb));
        check("fwd_datab",  fwd_datab,       db);
    endtask

    // Called just after a negedge: apply inputs, check, clock, update model.
    task automatic drive(input logic v, input logic [3:0] r, input logic [31:0] d,
                         input logic s, input logic [3:0] qa, input logic [3:0] qb);
        in_valid   = v;
        in_reg     = r;
        in_data    = d;
        stall      = s;
        query_rega = qa;
        query_regb = qb;
        #1;
        check_all();
        @(posedge clk);
        model_step(v, r, d, s);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic s);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 32'd0, s, 4'd0, 4'd0);
    endtask

    initial begin
        rst_f      = 1'b0;
        in_valid   = 1'b0;
        in_reg     = '0;
        in_data    = '0;
        stall      = 1'b0;
        query_rega = 4'd3;
        query_regb = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_f = 1'b1;

        // Single write to R3, then observe the one-cycle write pulse.
        drive(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd3, 4'd0);
        idle(3, 1'b0);

        // Fill while stalled, offer a fifth entry, then drain in order.
        for (int i = 1; i <= 4; i++)
            drive(1'b1, 4'(i), 32'(i * 32'h11), 1'b1, 4'(i), 4'd2);
        drive(1'b1, 4'd9, 32'h55, 1'b1, 4'd9, 4'd4);
        idle(6, 1'b0);

        // Forwarding priority between two entries for R5.
        drive(1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 4'd5);
        drive(1'b1, 4'd5, 32'h2, 1'b1, 4'd5, 4'd5);
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd5, 4'd5);

        // R0 is swallowed and never forwards.
        drive(1'b1, 4'd0, 32'hDEAD, 1'b0, 4'd0, 4'd0);
        idle(2, 1'b0);

        // Steady push/pop at count 2 across many pointer wraps.
        drive(1'b1, 4'd7, 32'h700, 1'b1, 4'd7, 4'd8);
        drive(1'b1, 4'd8, 32'h800, 1'b1, 4'd7, 4'd8);
        for (int i = 0; i < 8 * DEPTH + 2; i++)
            drive(1'b1, 4'(1 + (i % 15)), 32'(32'h1000 + i), 1'b0, 4'(1 + (i % 15)), 4'(1 + ((i + 14) % 15)));
        check("wrap_count", 32'(count), 32'd2);
        idle(4, 1'b0);

        // Asynchronous reset mid-cycle with three pending entries.
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd6, 32'(32'h60 + i), 1'b1, 4'd6, 4'd6);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd6, 4'd6);
        #2;
        rst_f = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_f = 1'b1;
        idle(5, 1'b0);

        // Randomized traffic with biased stall and a small register range.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
        end
        idle(DEPTH + 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, 4, number of pending write-back entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_f  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  producer (ALU/memory result) offers a write-back.
REQ-005 in_ready  output  1  queue can accept; handshake completes when in_valid && in_ready at posedge.
REQ-006 in_reg  input  4  destination register number.
REQ-007 in_data  input  32  result value.
REQ-008 stall  input  1  when 1, no entry is drained this cycle.
REQ-009 write_reg  output  4  register-file write address, registered.
REQ-010 write_data  output  32  register-file write data, registered.
REQ-011 rf_we  output  1  register-file write enable, registered; high for exactly one cycle per drained entry.
REQ-012 query_rega / query_regb  input  4 each  register numbers being read by the decode stage.
REQ-013 fwd_hita / fwd_hitb  output  1 each  a pending, unwritten value exists for the queried register.
REQ-014 fwd_dataa / fwd_datab  output  32 each  newest pending value for the queried register; 0 when no hit.
REQ-015 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-016 empty / full  output  1 each  count==0 / count==DEPTH.

Function
REQ-017 Storage is a circular FIFO of DEPTH entries {reg[3:0], data[31:0]}, with head and tail pointers wrapping modulo DEPTH.
REQ-018 in_ready = !full, derived from registered state only; no combinational path from in_valid.
REQ-019 Accepted entry with in_reg==0 is consumed and discarded: no storage, no count change, no rf_we.
REQ-020 Drain: at posedge, if !stall and count>0, head pops; rf_we<=1, write_reg<=head.reg, write_data<=head.data.
REQ-021 At posedge with stall==1 or count==0, rf_we<=0; write_reg and write_data hold their previous values.
REQ-022 Latency: entry accepted at edge N into an empty, unstalled queue pops at edge N+1, giving rf_we=1 during cycle N+1..N+2, and the register file captures it at edge N+2.
REQ-023 Simultaneous accept and pop in the same cycle: both occur and count is unchanged; when full, in_ready=0 even if a pop occurs that cycle (no pass-through).
REQ-024 Drain order is strictly FIFO; multiple entries to the same register all drain in order.
REQ-025 Forwarding search set: all stored entries plus the output stage when rf_we==1, with the output stage oldest; the newest match (nearest tail) wins.
REQ-026 Forwarding is combinational from registered state and the query inputs; a query of 0 never hits.
REQ-027 An entry being accepted in the current cycle is not visible to forwarding until after the edge.
REQ-028 count never exceeds DEPTH nor underflows; in_valid while full has no effect on state.

Reset
REQ-029 When rst_f==0, immediately set head=0, tail=0, count=0, rf_we=0, write_reg=0, write_data=0, and invalidate storage contents.
REQ-030 While in reset and after release: in_ready=1, empty=1, full=0, fwd_hita=fwd_hitb=0, fwd_dataa=fwd_datab=0.
REQ-031 Reset asserted mid-operation discards all pending entries; no rf_we pulse is produced for them after release.

Verification
REQ-032 Single write: accept {R3, 0x0000_00AA} at edge 1 -> rf_we=1, write_reg=3, write_data=0xAA after edge 2; rf_we=0 after edge 3.
REQ-033 Fill with stall=1: accept R1..R4 (data 0x11..0x44) -> full=1, in_ready=0, count=4; a 5th offer is ignored; release stall -> rf_we pulses on 4 consecutive cycles in order R1..R4, then empty=1.
REQ-034 Forwarding priority with stall=1: enqueue {R5,0x1}, {R5,0x2}, query_rega=5 -> fwd_hita=1, fwd_dataa=0x2; after both drain -> fwd_hita=0, fwd_dataa=0.
REQ-035 R0 handling: accept {R0, 0xDEAD} -> count stays 0, no rf_we; query_regb=0 -> fwd_hitb=0.
REQ-036 Simultaneous accept and pop with count=2 and stall=0 -> count remains 2 and the FIFO order is preserved across 8 pointer wrap-arounds.
REQ-037 Pull rst_f low asynchronously with count=3 mid-cycle -> rf_we, count and fwd_hita drop to 0 before the next edge; no writes appear after release.
